// File: rtl/i2c_pkg.sv
// Shared I2C definitions: one-hot controller states, bit-slot phases and R/W encoding.
// Also used by the secondary block, so encodings here must stay stable.
package i2c_pkg;

  localparam int unsigned I2C_STATES = 9;
  localparam int unsigned I2C_BYTES  = 2;

  typedef enum logic [I2C_STATES-1:0] {
    StIdle  = 9'b0_0000_0001,
    StStart = 9'b0_0000_0010,
    StAddr  = 9'b0_0000_0100,
    StAckA  = 9'b0_0000_1000,
    StWrite = 9'b0_0001_0000,
    StAckW  = 9'b0_0010_0000,
    StRead  = 9'b0_0100_0000,
    StAckR  = 9'b0_1000_0000,
    StStop  = 9'b1_0000_0000
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/i2c_scl_gen.sv
// Quarter-period divider and 2-bit phase counter; SCL is low in q0/q1, high in q2/q3.
// Counters sit at zero while not running so every transfer starts on a clean q0.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  output logic [1:0] o_phase,
  output logic       o_adv,
  output logic       o_scl
);

  localparam int unsigned CntW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [CntW-1:0] r_qcnt;
  logic [1:0]      r_phase;

  assign o_adv   = i_run && (r_qcnt == CntW'(QUARTER - 1));
  assign o_phase = r_phase;
  assign o_scl   = !i_run || r_phase[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_qcnt  <= '0;
      r_phase <= Q0;
    end else if (!i_run) begin
      r_qcnt  <= '0;
      r_phase <= Q0;
    end else if (o_adv) begin
      r_qcnt  <= '0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_qcnt  <= r_qcnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_primary.sv
// I2C primary: START, 7-bit address + R/W, two data bytes written or read, STOP.
// Reads ACK the high byte and NACK the low byte; RD_DATA updates only on a clean read.
module i2c_primary
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_stb,
  input  logic        i_rnw,
  input  logic [6:0]  i_i2c_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_sda_in,
  output logic        o_scl,
  output logic        o_sda_out,
  output logic        o_sda_oe,
  output logic [15:0] o_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_nack
);

  localparam logic LastByte = 1'(I2C_BYTES - 1);

  i2c_state_e  r_state, w_state_nxt;
  logic [7:0]  r_addr_rnw, w_addr_rnw_nxt;
  logic [15:0] r_wr_data, w_wr_data_nxt;
  logic [15:0] r_rx, w_rx_nxt;
  logic [15:0] r_rd_data, w_rd_data_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic        r_byte, w_byte_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_nack, w_nack_nxt;
  logic        r_done, w_done_nxt;

  logic       w_busy, w_adv, w_scl_base, w_sample, w_slot_end, w_tx_bit;
  logic       w_scl, w_sda, w_oe;
  logic [1:0] w_phase;

  assign w_busy = (r_state != StIdle);

  i2c_scl_gen #(
    .QUARTER (QUARTER)
  ) u_scl_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_run   (w_busy),
    .o_phase (w_phase),
    .o_adv   (w_adv),
    .o_scl   (w_scl_base)
  );

  assign w_sample   = w_adv && (w_phase == Q2);
  assign w_slot_end = w_adv && (w_phase == Q3);
  assign w_tx_bit   = (r_state == StAddr)   ? r_addr_rnw[r_bit_idx] :
                      (r_byte == LastByte) ? r_wr_data[r_bit_idx]  :
                                             r_wr_data[{1'b1, r_bit_idx}];

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_rnw_nxt = r_addr_rnw;
    w_wr_data_nxt  = r_wr_data;
    w_rx_nxt       = r_rx;
    w_rd_data_nxt  = r_rd_data;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_nxt     = r_byte;
    w_ack_nxt      = r_ack;
    w_nack_nxt     = r_nack;
    w_done_nxt     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start_stb) begin
          w_state_nxt    = StStart;
          w_addr_rnw_nxt = {i_i2c_addr, i_rnw};
          w_wr_data_nxt  = i_wr_data;
          w_nack_nxt     = 1'b0;
          w_bit_idx_nxt  = 3'd7;
          w_byte_nxt     = 1'b0;
        end
      end
      StStart: if (w_slot_end) w_state_nxt = StAddr;
      StAddr, StWrite: begin
        if (w_slot_end) begin
          w_bit_idx_nxt = r_bit_idx - 3'd1;
          if (r_bit_idx == 3'd0) w_state_nxt = (r_state == StAddr) ? StAckA : StAckW;
        end
      end
      StAckA, StAckW: begin
        if (w_sample) w_ack_nxt = i_sda_in;
        if (w_slot_end) begin
          if (r_ack) begin
            w_nack_nxt  = 1'b1;
            w_state_nxt = StStop;
          end else if (r_state == StAckA) begin
            w_state_nxt = (r_addr_rnw[0] == RW_READ) ? StRead : StWrite;
          end else if (r_byte == LastByte) begin
            w_state_nxt = StStop;
          end else begin
            w_byte_nxt  = LastByte;
            w_state_nxt = StWrite;
          end
        end
      end
      StRead: begin
        if (w_sample) w_rx_nxt = {r_rx[14:0], i_sda_in};
        if (w_slot_end) begin
          w_bit_idx_nxt = r_bit_idx - 3'd1;
          if (r_bit_idx == 3'd0) w_state_nxt = StAckR;
        end
      end
      StAckR: begin
        if (w_slot_end) begin
          if (r_byte == LastByte) begin
            w_state_nxt = StStop;
          end else begin
            w_byte_nxt  = LastByte;
            w_state_nxt = StRead;
          end
        end
      end
      StStop: begin
        if (w_slot_end) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
          if ((r_addr_rnw[0] == RW_READ) && !r_nack) w_rd_data_nxt = r_rx;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // START/STOP override the slot SCL so their SDA edges land while SCL is high.
  always_comb begin
    w_scl = 1'b1;
    w_oe  = 1'b0;
    w_sda = 1'b1;
    unique case (r_state)
      StIdle: begin
      end
      StStart: begin
        w_oe  = 1'b1;
        w_sda = ~w_phase[1];
      end
      StAddr, StWrite: begin
        w_scl = w_scl_base;
        w_oe  = 1'b1;
        w_sda = w_tx_bit;
      end
      StAckA, StAckW, StRead: w_scl = w_scl_base;
      StAckR: begin
        w_scl = w_scl_base;
        w_oe  = 1'b1;
        w_sda = (r_byte == LastByte);
      end
      StStop: begin
        if (w_phase == Q0 || w_phase == Q1) begin
          w_scl = (w_phase == Q1);
          w_oe  = 1'b1;
          w_sda = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign o_scl     = w_scl;
  assign o_sda_oe  = w_oe;
  assign o_sda_out = w_oe ? w_sda : 1'b1;
  assign o_rd_data = r_rd_data;
  assign o_busy    = w_busy;
  assign o_done    = r_done;
  assign o_nack    = r_nack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_addr_rnw <= '0;
      r_wr_data  <= '0;
      r_rx       <= '0;
      r_rd_data  <= '0;
      r_bit_idx  <= 3'd7;
      r_byte     <= 1'b0;
      r_ack      <= 1'b0;
      r_nack     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr_rnw <= w_addr_rnw_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rx       <= w_rx_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte     <= w_byte_nxt;
      r_ack      <= w_ack_nxt;
      r_nack     <= w_nack_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_primary.sv
// Bench: QUARTER=1 and QUARTER=3 primaries sharing one behavioural secondary at address 7'h2A.
// Expected results come from transfer-level rules: length, ACK/NACK outcome, payloads.
module tb_i2c_primary;

  localparam logic [6:0] SecAddr = 7'h2A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb1, stb3, rnw, sel, sec_sda;
  logic [6:0]  addr;
  logic [15:0] wdata;

  logic        scl1, sdo1, oe1, busy1, done1, nack1;
  logic        scl3, sdo3, oe3, busy3, done3, nack3;
  logic [15:0] rd1, rd3;

  logic        b_scl, b_sdo, b_oe, b_sda, b_busy, b_done, b_nack;
  logic [15:0] b_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int n_startc = 0;
  int n_stopc  = 0;
  int n_done   = 0;

  logic [15:0] s_wrs = 16'h0;
  logic [15:0] s_rds = 16'h0;
  logic [1:0]  s_mack [2];
  logic [15:0] exp_rd [2];
  logic [15:0] exp_wrs;

  always #5 clk = ~clk;

  i2c_primary #(.QUARTER(1)) u_dut1 (
    .i_clk (clk), .i_rst_n (rst_n), .i_start_stb (stb1), .i_rnw (rnw),
    .i_i2c_addr (addr), .i_wr_data (wdata), .i_sda_in (sec_sda),
    .o_scl (scl1), .o_sda_out (sdo1), .o_sda_oe (oe1), .o_rd_data (rd1),
    .o_busy (busy1), .o_done (done1), .o_nack (nack1)
  );

  i2c_primary #(.QUARTER(3)) u_dut3 (
    .i_clk (clk), .i_rst_n (rst_n), .i_start_stb (stb3), .i_rnw (rnw),
    .i_i2c_addr (addr), .i_wr_data (wdata), .i_sda_in (sec_sda),
    .o_scl (scl3), .o_sda_out (sdo3), .o_sda_oe (oe3), .o_rd_data (rd3),
    .o_busy (busy3), .o_done (done3), .o_nack (nack3)
  );

  assign b_scl  = sel ? scl3  : scl1;
  assign b_sdo  = sel ? sdo3  : sdo1;
  assign b_oe   = sel ? oe3   : oe1;
  assign b_busy = sel ? busy3 : busy1;
  assign b_done = sel ? done3 : done1;
  assign b_nack = sel ? nack3 : nack1;
  assign b_rd   = sel ? rd3   : rd1;
  assign b_sda  = sec_sda & b_sdo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Bus watcher plus behavioural secondary, both evaluated mid-cycle.
  initial begin
    logic p_scl, p_sda, c_scl, c_sda, s_act, s_addrd, s_rd;
    logic [7:0] s_sh, s_hi, rb;
    int s_bit, s_byte;
    p_scl = 1'b1; p_sda = 1'b1; sec_sda = 1'b1;
    s_act = 1'b0; s_addrd = 1'b0; s_rd = 1'b0; s_sh = '0; s_hi = '0;
    s_bit = 0; s_byte = 0; s_mack[0] = '0; s_mack[1] = '0;
    forever begin
      @(negedge clk);
      c_scl = b_scl;
      c_sda = b_sda;
      if (p_scl && c_scl && p_sda && !c_sda) n_startc++;
      if (p_scl && c_scl && !p_sda && c_sda) n_stopc++;
      if (b_done) n_done++;
      rb = (s_byte == 1) ? s_rds[15:8] : s_rds[7:0];
      if (!rst_n) begin
        s_act = 1'b0; sec_sda = 1'b1;
      end else if (p_scl && c_scl && p_sda && !c_sda) begin
        s_act = 1'b1; s_bit = 0; s_byte = 0; s_addrd = 1'b0; sec_sda = 1'b1;
        s_mack[0] = '0; s_mack[1] = '0;
      end else if (p_scl && c_scl && !p_sda && c_sda) begin
        s_act = 1'b0; sec_sda = 1'b1;
      end else if (s_act && !p_scl && c_scl) begin
        if (s_bit < 8) s_sh = {s_sh[6:0], c_sda};
        else if (s_rd && s_byte >= 1 && s_byte <= 2) s_mack[s_byte-1] = {b_oe, b_sdo};
        s_bit++;
      end else if (s_act && p_scl && !c_scl) begin
        if (s_bit == 8) begin
          if (s_byte == 0) begin
            s_addrd = (s_sh[7:1] == SecAddr);
            s_rd    = s_sh[0];
            sec_sda = !s_addrd;
          end else if (!s_rd) begin
            if (s_byte == 1) s_hi = s_sh;
            else s_wrs = {s_hi, s_sh};
            sec_sda = 1'b0;
          end else begin
            sec_sda = 1'b1;
          end
        end else if (s_bit == 9) begin
          s_byte++;
          s_bit = 0;
          rb = (s_byte == 1) ? s_rds[15:8] : s_rds[7:0];
          if (!s_addrd) begin
            s_act = 1'b0; sec_sda = 1'b1;
          end else if (s_rd && s_byte <= 2) begin
            sec_sda = rb[7];
          end else begin
            sec_sda = 1'b1;
          end
        end else if (s_rd && s_addrd && s_byte >= 1 && s_bit >= 1 && s_bit <= 7) begin
          sec_sda = rb[7-s_bit];
        end
      end
      p_scl = c_scl;
      p_sda = c_sda;
    end
  end

  // One transfer on the selected primary; inj_at pulses a stray strobe, rst_at aborts via reset.
  task automatic txn(input logic q3, input logic rd, input logic [6:0] a, input logic [15:0] wd,
                     input int inj_at, input int rst_at);
    int cyc, st0, sp0, dn0, qn, exp_len;
    logic acked;
    qn      = q3 ? 3 : 1;
    acked   = (a == SecAddr);
    exp_len = 4 * qn * (acked ? 29 : 11);
    sel     = q3;
    @(negedge clk);
    rnw = rd; addr = a; wdata = wd;
    if (q3) stb3 = 1'b1; else stb1 = 1'b1;
    @(negedge clk);
    stb1 = 1'b0; stb3 = 1'b0;
    rnw = 1'($urandom); addr = 7'($urandom); wdata = 16'($urandom);
    st0 = n_startc; sp0 = n_stopc; dn0 = n_done;
    check("busy_rise", 32'(b_busy), 32'd1);
    check("nack_clear", 32'(b_nack), 32'd0);
    cyc = 0;
    while (b_busy && cyc < 2000) begin
      if (cyc == inj_at) begin
        wdata = ~wd;
        if (q3) stb3 = 1'b1; else stb1 = 1'b1;
      end else begin
        stb1 = 1'b0; stb3 = 1'b0;
      end
      if (cyc == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_scl", 32'(b_scl), 32'd1);
        check("rst_oe", 32'(b_oe), 32'd0);
        check("rst_sdo", 32'(b_sdo), 32'd1);
        check("rst_busy", 32'(b_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    stb1 = 1'b0; stb3 = 1'b0;
    if (rd && acked) exp_rd[q3] = s_rds;
    if (!rd && acked) exp_wrs = wd;
    check("length", 32'(cyc), 32'(exp_len));
    check("done_at_end", 32'(b_done), 32'd1);
    check("nack", 32'(b_nack), 32'(!acked));
    check("rd_data", 32'(b_rd), 32'(exp_rd[q3]));
    check("sec_wr_data", 32'(s_wrs), 32'(exp_wrs));
    if (rd && acked) begin
      check("ack_r_hi", 32'(s_mack[0]), 32'b10);
      check("ack_r_lo", 32'(s_mack[1]), 32'b11);
    end
    check("start_edges", 32'(n_startc - st0), 32'd1);
    check("stop_edges", 32'(n_stopc - sp0), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(b_done), 32'd0);
    check("done_count", 32'(n_done - dn0), 32'd1);
    check("nack_hold", 32'(b_nack), 32'(!acked));
  endtask

  initial begin
    logic [6:0] ra;
    stb1 = 1'b0; stb3 = 1'b0; rnw = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_wrs = '0;
    repeat (2) @(negedge clk);
    check("reset_scl", 32'(scl1), 32'd1);
    check("reset_sdo", 32'(sdo1), 32'd1);
    check("reset_oe", 32'(oe1), 32'd0);
    check("reset_busy", 32'({busy1, busy3}), 32'd0);
    check("reset_done", 32'({done1, done3}), 32'd0);
    check("reset_nack", 32'({nack1, nack3}), 32'd0);
    check("reset_rd", 32'({rd1, rd3}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    txn(1'b0, 1'b0, SecAddr, 16'hBEEF, -1, -1);
    s_rds = 16'hA5C3;
    txn(1'b0, 1'b1, SecAddr, 16'h0000, -1, -1);
    txn(1'b0, 1'b1, 7'h11, 16'h0000, -1, -1);
    txn(1'b0, 1'b0, SecAddr, 16'hC0DE, 60, -1);
    txn(1'b0, 1'b0, SecAddr, 16'h5555, -1, 52);
    repeat (3) @(negedge clk);
    txn(1'b0, 1'b0, SecAddr, 16'h1234, -1, -1);
    txn(1'b1, 1'b0, SecAddr, 16'h00FF, -1, -1);

    for (int i = 0; i < 12; i++) begin
      ra = 7'($urandom);
      if (ra == SecAddr) ra = ra ^ 7'h01;
      if ($urandom_range(0, 2) != 0) ra = SecAddr;
      s_rds = 16'($urandom);
      txn(1'($urandom), 1'($urandom), ra, 16'($urandom), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
